// File: rtl/fcs_pkg.sv
// Shared CRC32 definitions for the serial transmit generator and the receive-side FCS checker.
// Pure definitions: no latency and no flow control.
package fcs_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2
    } fcs_state_e;

    // One MSB-first shift of the CRC register for a single serial bit.
    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic b);
        crc32_step = {crc[30:0], 1'b0} ^ (CRC32_POLY & {32{b ^ crc[31]}});
    endfunction

endpackage

// File: rtl/fcs_serial_lfsr.sv
// Bit-serial CRC32 register: clear reloads INIT_VAL, and a bit enabled in the same cycle steps from INIT_VAL.
// Latency: one clock from an enabled bit to the updated register. No backpressure: a bit is taken whenever en_i is high.
module fcs_serial_lfsr
    import fcs_pkg::*;
#(
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] base;

    always_comb begin
        base  = clr_i ? INIT_VAL : crc_q;
        crc_d = en_i ? crc32_step(base, bit_i) : base;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT_VAL;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/fcs_checker.sv
// Receive-side FCS checker: runs CRC32 over a serial payload+FCS frame and reports the verdict and the length.
// Latency: done pulses two clocks after the frame_end cycle. No backpressure: every bit and strobe is taken as presented.
module fcs_checker
    import fcs_pkg::*;
#(
    parameter logic [31:0] STATE_INIT_VAL = 32'h0000_0000,
    parameter logic [31:0] RESIDUE        = 32'h0000_0000,
    parameter logic [15:0] MAX_BITS       = 16'd4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        bit_valid,
    input  logic        bit_in,
    input  logic        frame_end,
    output logic        busy,
    output logic        done,
    output logic        fcs_ok,
    output logic        len_err,
    output logic [15:0] bit_cnt,
    output logic [31:0] crc_val
);

    localparam logic [15:0] MIN_BITS = 16'd33;

    fcs_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        over_q, over_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        lerr_q, lerr_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic        accept;
    logic        chk_len_err;
    logic [31:0] crc;

    // A frame_start bit always belongs to the new frame, whatever state we were in.
    assign accept = bit_valid && (frame_start || (state_q == RUN));

    fcs_serial_lfsr #(
        .INIT_VAL (STATE_INIT_VAL)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (frame_start),
        .en_i  (accept),
        .bit_i (bit_in),
        .crc_o (crc)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        over_d      = over_q;
        done_d      = 1'b0;
        ok_d        = ok_q;
        lerr_d      = lerr_q;
        bcnt_d      = bcnt_q;
        chk_len_err = (cnt_q < MIN_BITS) || over_q;

        // The verdict uses the finished frame's register even if a new frame starts on this edge.
        if (state_q == CHECK) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ok_d    = (crc == RESIDUE) && !chk_len_err;
            lerr_d  = chk_len_err;
            bcnt_d  = cnt_q;
        end

        if (frame_start) begin
            state_d = RUN;
            cnt_d   = {15'd0, bit_valid};
            over_d  = bit_valid && (MAX_BITS == 16'd0);
        end else if (state_q == RUN) begin
            if (bit_valid) begin
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (cnt_q >= MAX_BITS) begin
                    over_d = 1'b1;
                end
            end
            if (frame_end) begin
                state_d = CHECK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            over_q  <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            lerr_q  <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            over_q  <= over_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            lerr_q  <= lerr_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign fcs_ok  = ok_q;
    assign len_err = lerr_q;
    assign bit_cnt = bcnt_q;
    assign crc_val = crc;

endmodule

// File: tb/tb_fcs_checker.sv
// Randomized frame stimulus checked against a polynomial-division model; two DUTs differ only in MAX_BITS.
module tb_fcs_checker;

    typedef bit bitq_t[$];
    typedef struct packed {
        logic        ok_a;
        logic        le_a;
        logic        ok_b;
        logic        le_b;
        logic [15:0] cnt;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        frame_end = 1'b0;
    logic        busy_a, done_a, ok_a, le_a;
    logic        busy_b, done_b, ok_b, le_b;
    logic [15:0] cnt_a, cnt_b;
    logic [31:0] crc_a, crc_b;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_at[int];
    res_t held = '0;

    fcs_checker u_dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_end(frame_end), .busy(busy_a), .done(done_a), .fcs_ok(ok_a), .len_err(le_a),
        .bit_cnt(cnt_a), .crc_val(crc_a)
    );

    fcs_checker #(.MAX_BITS(16'd64)) u_dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .frame_end(frame_end), .busy(busy_b), .done(done_b), .fcs_ok(ok_b), .len_err(le_b),
        .bit_cnt(cnt_b), .crc_val(crc_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Remainder of M(x)*x^32 divided by the generator, by long division over the bit string.
    function automatic logic [31:0] model_crc(input bitq_t m);
        bit          a[$];
        logic [32:0] g;
        logic [31:0] r;
        g = 33'h1_04C1_1DB7;
        a = m;
        for (int i = 0; i < 32; i++) a.push_back(1'b0);
        for (int i = 0; i < m.size(); i++)
            if (a[i]) for (int j = 0; j < 33; j++) a[i+j] = a[i+j] ^ g[32-j];
        for (int j = 0; j < 32; j++) r[31-j] = a[m.size()+j];
        return r;
    endfunction

    function automatic bitq_t make_good(input int plen);
        bitq_t       q;
        logic [31:0] f;
        for (int i = 0; i < plen; i++) q.push_back(1'($urandom_range(0, 1)));
        f = model_crc(q);
        for (int i = 31; i >= 0; i--) q.push_back(f[i]);
        return q;
    endfunction

    function automatic res_t model_result(input bitq_t q);
        res_t r;
        int   n;
        logic good;
        n      = q.size();
        good   = (model_crc(q) == 32'h0);
        r.le_a = (n < 33) || (n > 4096);
        r.le_b = (n < 33) || (n > 64);
        r.ok_a = good && !r.le_a;
        r.ok_b = good && !r.le_b;
        r.cnt  = (n > 65535) ? 16'hFFFF : 16'(n);
        return r;
    endfunction

    task automatic step(input logic fs, input logic bv, input logic b, input logic fe);
        @(posedge clk);
        #1;
        frame_start = fs;
        bit_valid   = bv;
        bit_in      = b;
        frame_end   = fe;
    endtask

    task automatic idle_noise(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // end_mode: 0 = end on last bit, 1 = end in a later cycle, 2 = leave open. collide: frame_end with frame_start.
    task automatic run_frame(input bitq_t bits, input int end_mode, input bit collide);
        int n;
        int i;
        bit first_with_start;
        n = bits.size();
        i = 0;
        first_with_start = ($urandom_range(0, 1) == 1) && (n > 1);
        if (first_with_start) begin
            step(1'b1, 1'b1, bits[0], collide);
            i = 1;
        end else begin
            step(1'b1, 1'b0, 1'($urandom_range(0, 1)), collide);
        end
        while (i < n) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                step(1'b0, 1'b1, bits[i], (i == n - 1) && (end_mode == 0));
                i++;
            end
        end
        if (end_mode == 1) begin
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        end
        if (end_mode != 2) exp_at[cyc + 2] = model_result(bits);
    endtask

    task automatic expect_lit(input string name, input bit chk_crc, input logic eok_a, input logic ele_a,
                              input logic eok_b, input logic ele_b, input logic [15:0] ecnt);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        if (chk_crc) begin
            check({name, "_busy_check"}, 32'(busy_a), 32'd1);
            check({name, "_crc_check"}, crc_a, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check({name, "_done"}, 32'(done_a), 32'd1);
        check({name, "_ok_a"}, 32'(ok_a), 32'(eok_a));
        check({name, "_le_a"}, 32'(le_a), 32'(ele_a));
        check({name, "_ok_b"}, 32'(ok_b), 32'(eok_b));
        check({name, "_le_b"}, 32'(le_b), 32'(ele_b));
        check({name, "_cnt"}, 32'(cnt_a), 32'(ecnt));
    endtask

    // Per-cycle comparison of both DUTs against the model's scheduled results.
    always @(negedge clk) begin
        bit ed;
        ed = 1'b0;
        if (rst) begin
            held = '0;
        end else if (exp_at.exists(cyc)) begin
            ed   = 1'b1;
            held = exp_at[cyc];
            exp_at.delete(cyc);
        end
        check("done_a", 32'(done_a), 32'(ed));
        check("done_b", 32'(done_b), 32'(ed));
        check("fcs_ok_a", 32'(ok_a), 32'(held.ok_a));
        check("len_err_a", 32'(le_a), 32'(held.le_a));
        check("fcs_ok_b", 32'(ok_b), 32'(held.ok_b));
        check("len_err_b", 32'(le_b), 32'(held.le_b));
        check("bit_cnt_a", 32'(cnt_a), 32'(held.cnt));
        check("bit_cnt_b", 32'(cnt_b), 32'(held.cnt));
    end

    initial begin
        bitq_t       g;
        bitq_t       q;
        bitq_t       q2;
        logic [31:0] p;
        int          kind;
        int          em;

        p = 32'h04C1_1DB7;
        g.push_back(1'b1);
        for (int i = 31; i >= 0; i--) g.push_back(p[i]);

        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        check("rst_crc", crc_a, 32'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        q.push_back(1'b1);
        check("model_one_bit", model_crc(q), 32'h04C1_1DB7);
        check("model_golden", model_crc(g), 32'h0);

        run_frame(g, 0, 1'b0);
        expect_lit("good", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd33);

        q = g;
        q[22] = ~q[22];
        run_frame(q, 0, 1'b0);
        expect_lit("flip10", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd33);

        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(1'b0);
        run_frame(q, 1, 1'b0);
        expect_lit("short", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd20);

        q = make_good(40);
        run_frame(q, 0, 1'b0);
        expect_lit("len72", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd72);

        run_frame(g, 0, 1'b0);
        q = make_good(50);
        run_frame(q, 1, 1'b0);
        idle_noise(3);

        q.delete();
        for (int i = 0; i < 10; i++) q.push_back(1'($urandom_range(0, 1)));
        run_frame(q, 2, 1'b0);
        run_frame(g, 0, 1'b1);
        idle_noise(4);

        run_frame(g, 0, 1'b0);
        idle_noise(3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        #2;
        rst = 1'b1;
        frame_start = 1'b0;
        bit_valid = 1'b0;
        #1;
        check("arst_done", 32'(done_a), 32'd0);
        check("arst_ok", 32'(ok_a), 32'd0);
        check("arst_cnt", 32'(cnt_a), 32'd0);
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_crc", crc_a, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(g, 0, 1'b0);
        expect_lit("after_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd33);

        for (int f = 0; f < 120; f++) begin
            kind = $urandom_range(0, 3);
            em   = $urandom_range(0, 1);
            if (kind <= 1) begin
                q = make_good($urandom_range(1, 90));
            end else if (kind == 2) begin
                q = make_good($urandom_range(1, 60));
                q[$urandom_range(0, q.size() - 1)] ^= 1'b1;
            end else begin
                q.delete();
                repeat ($urandom_range(2, 70)) q.push_back(1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 9) == 0) begin
                run_frame(q, 2, 1'b0);
                q2 = make_good($urandom_range(1, 40));
                run_frame(q2, em, 1'b1);
            end else begin
                run_frame(q, em, 1'b0);
            end
            idle_noise($urandom_range(0, 3));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("pending_results", 32'(exp_at.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
